genome_core_sequencer: RTL and testbench
========================================

# genome_core_sequencer

Lifecycle controller between the UART genome loader and the ATOMiK core. It snapshots each completed genome (frequency, 256-bit DNA, OTP policy) into a shadow register. It then sequences the core through reset, prime and run, and arbitrates word-wise DNA reads from the core. Reads enforce burn-on-read when OTP is set, and an optional run lease retires the genome automatically.

## Interface
- ARM_CYCLES, 4: cycles core_rst_n is held low before priming (≥1).
- LEASE_CYCLES, 0: max RUN cycles per genome; 0 = unlimited.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_busy  in  1  loader busy level.
- ld_enable  in  1  loader core_enable level; rising edge = genome complete.
- ld_otp  in  1  loader OTP policy bit.
- ld_freq  in  32  loader frequency word.
- ld_dna  in  256  loader DNA image.
- rd_req  in  1  DNA word read request, one per cycle.
- rd_addr  in  3  word index; word i = DNA[32i+31:32i].
- rd_valid  out  1  read response strobe.
- rd_data  out  32  read data.
- rd_err  out  1  read refused (not RUN, or word burned).
- core_rst_n  out  1  core synchronous reset, active-low.
- core_run  out  1  core enable.
- freq_out  out  32  shadow frequency; 0 outside PRIME/RUN.
- burn_mask  out  8  bit i set = word i consumed under OTP.
- seq_state  out  3  current state encoding.

## Operation
- States: EMPTY=0, LOADING=1, ARMING=2, PRIME=3, RUN=4, SPENT=5.
- load_done = ld_enable & ~ld_enable_q (registered previous value); busy_rise = ld_busy & ~ld_busy_q.
- From any state, busy_rise → LOADING. Clear burn_mask. Shadow is kept until the next capture.
- LOADING:
  - load_done → capture ld_freq, ld_dna, ld_otp into shadow; go to ARMING with arm_cnt = ARM_CYCLES−1.
  - Else ld_busy low (magic abort) → EMPTY and zero the shadow.
- ARMING: decrement arm_cnt; at 0 → PRIME.
- PRIME: one cycle → RUN; load lease_cnt = LEASE_CYCLES−1.
- RUN:
  - Serve reads.
  - If LEASE_CYCLES≠0, decrement lease_cnt; at 0 → SPENT.
  - If OTP and the current read sets the last burn_mask bit → SPENT.
  - If both conditions occur on the same cycle → SPENT once.
- SPENT: shadow DNA zeroed on entry; wait for busy_rise.
- Outputs are decoded from registered state only:
  - core_rst_n = 1 in PRIME and RUN.
  - core_run = 1 in RUN.
- Read in RUN, word not burned: rd_data = shadow word, rd_err = 0. If OTP, zero the shadow word and set burn_mask[addr] on the same edge.
- Read in any other case: rd_data = 0, rd_err = 1.
- Busy_rise on the same cycle as rd_req: the load wins, and the read returns rd_err = 1.
- Reset values:
  - state EMPTY.
  - Outputs core_rst_n, core_run, rd_valid, rd_err = 0; rd_data, freq_out, burn_mask = 0.
  - Internal shadow registers zeroed.

## Timing
- rd_req at cycle N → rd_valid and response at N+1. Back-to-back requests are accepted every cycle with no stall.
- Capture edge at cycle T (load_done high) → ARMING during T+1 .. T+ARM_CYCLES → PRIME at T+ARM_CYCLES+1 → RUN (core_run = 1) at T+ARM_CYCLES+2.
- Lease: core_run is high for exactly LEASE_CYCLES cycles.
- OTP: the last burning read at N → state SPENT and core_run = 0 at N+1, with the response still valid at N+1.
- busy_rise at N → core_run = 0 and core_rst_n = 0 at N+1.
- Asynchronous reset mid-operation: all outputs take reset values immediately, and no read response is emitted afterward.

## Structure
- Shared package atomik_pkg holds:
  - state encoding constants S_EMPTY … S_SPENT,
  - DNA_WORDS = 8,
  - DNA_W = 256.
- Single module, no sub-modules. The shadow DNA is 8×32 registers, not RAM, because of per-word clear.

## Test plan
- ARM_CYCLES=4, OTP=0, DNA word i = 0x11111111·(i+1), freq 0x00001000 → core_rst_n low 4 cycles, PRIME 1 cycle, then RUN. freq_out = 0x00001000 from PRIME onward. Read addr 3 → 0x44444444 with rd_err = 0.
- OTP=1 → read addr 2 returns 0x33333333 and sets burn_mask = 0x04. Second read of addr 2 returns 0 with rd_err = 1. Reading the remaining 7 words → SPENT, core_run = 0 next cycle, burn_mask = 0xFF.
- LEASE_CYCLES=10, OTP=0 → core_run high exactly 10 cycles, then seq_state = 5. Subsequent reads return rd_err = 1.
- ld_busy 1→0 without an ld_enable rise → seq_state = EMPTY, freq_out = 0, core_run stays 0.
- RUN with rd_req and ld_busy rising on the same cycle → rd_err = 1, seq_state = LOADING, core_run = 0 next cycle.
- rst_n asserted during ARMING → immediate reset values. After release, a new load runs the full sequence from EMPTY.

Source files
------------

// File: rtl/atomik_pkg.sv
// Shared constants for the genome loader / ATOMiK core lifecycle.
package atomik_pkg;

  localparam int DNA_WORDS = 8;
  localparam int DNA_W     = 256;

  typedef enum logic [2:0] {
    S_EMPTY   = 3'd0,
    S_LOADING = 3'd1,
    S_ARMING  = 3'd2,
    S_PRIME   = 3'd3,
    S_RUN     = 3'd4,
    S_SPENT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/genome_core_sequencer.sv
// Lifecycle controller: snapshots a loaded genome, sequences the core through
// reset/prime/run and serves word-wise DNA reads with optional burn-on-read.
module genome_core_sequencer
  import atomik_pkg::*;
#(
  parameter int ARM_CYCLES   = 4,
  parameter int LEASE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_busy,
  input  logic             ld_enable,
  input  logic             ld_otp,
  input  logic [31:0]      ld_freq,
  input  logic [DNA_W-1:0] ld_dna,
  input  logic             rd_req,
  input  logic [2:0]       rd_addr,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic             rd_err,
  output logic             core_rst_n,
  output logic             core_run,
  output logic [31:0]      freq_out,
  output logic [7:0]       burn_mask,
  output logic [2:0]       seq_state
);

  localparam int AW = (ARM_CYCLES   > 1) ? $clog2(ARM_CYCLES)   : 1;
  localparam int LW = (LEASE_CYCLES > 1) ? $clog2(LEASE_CYCLES) : 1;

  seq_state_t     state;
  logic           ld_enable_q;
  logic           ld_busy_q;
  logic [31:0]    freq_q;
  logic           otp_q;
  logic [31:0]    dna_q [DNA_WORDS];
  logic [AW-1:0]  arm_cnt;
  logic [LW-1:0]  lease_cnt;

  logic           load_done;
  logic           busy_rise;
  logic           rd_ok;
  logic [7:0]     burn_next;
  logic           otp_spent;
  logic           lease_spent;

  // Edge detects and read acceptance; a load starting this cycle refuses the read.
  always_comb begin
    load_done   = ld_enable & ~ld_enable_q;
    busy_rise   = ld_busy & ~ld_busy_q;
    rd_ok       = rd_req && (state == S_RUN) && !busy_rise && !burn_mask[rd_addr];
    burn_next   = burn_mask | (8'd1 << rd_addr);
    otp_spent   = rd_ok && otp_q && (burn_next == '1);
    lease_spent = (LEASE_CYCLES != 0) && (state == S_RUN) && (lease_cnt == '0);
  end

  // State machine, shadow genome, burn tracking and registered read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      ld_enable_q <= 1'b0;
      ld_busy_q   <= 1'b0;
      freq_q      <= '0;
      otp_q       <= 1'b0;
      for (int unsigned i = 0; i < DNA_WORDS; i++) dna_q[i] <= '0;
      arm_cnt     <= '0;
      lease_cnt   <= '0;
      burn_mask   <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_err      <= 1'b0;
    end else begin
      ld_enable_q <= ld_enable;
      ld_busy_q   <= ld_busy;
      rd_valid    <= rd_req;
      rd_data     <= rd_ok ? dna_q[rd_addr] : '0;
      rd_err      <= rd_req && !rd_ok;
      if (rd_ok && otp_q) begin
        dna_q[rd_addr] <= '0;
        burn_mask      <= burn_next;
      end

      if (busy_rise) begin
        state     <= S_LOADING;
        burn_mask <= '0;
      end else begin
        case (state)
          S_LOADING: begin
            if (load_done) begin
              freq_q  <= ld_freq;
              otp_q   <= ld_otp;
              for (int unsigned i = 0; i < DNA_WORDS; i++) dna_q[i] <= ld_dna[32*i +: 32];
              arm_cnt <= AW'(ARM_CYCLES - 1);
              state   <= S_ARMING;
            end else if (!ld_busy) begin
              freq_q <= '0;
              otp_q  <= 1'b0;
              for (int unsigned i = 0; i < DNA_WORDS; i++) dna_q[i] <= '0;
              state  <= S_EMPTY;
            end
          end
          S_ARMING: begin
            if (arm_cnt == '0) state <= S_PRIME;
            else               arm_cnt <= arm_cnt - 1'b1;
          end
          S_PRIME: begin
            lease_cnt <= LW'(LEASE_CYCLES - 1);
            state     <= S_RUN;
          end
          S_RUN: begin
            // Lease expiry and last OTP burn may coincide; both retire once here.
            if (otp_spent || lease_spent) begin
              for (int unsigned i = 0; i < DNA_WORDS; i++) dna_q[i] <= '0;
              state <= S_SPENT;
            end else if (LEASE_CYCLES != 0) begin
              lease_cnt <= lease_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Core controls decoded from the registered state only.
  always_comb begin
    core_rst_n = (state == S_PRIME) || (state == S_RUN);
    core_run   = (state == S_RUN);
    freq_out   = core_rst_n ? freq_q : '0;
    seq_state  = state;
  end

endmodule

// File: tb/tb_genome_core_sequencer.sv
// Self-checking bench for genome_core_sequencer: read responses are scored
// against a queue filled from a small model of the shadow genome.
module tb_genome_core_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ld_busy, ld_enable, ld_otp;
  logic [31:0]  ld_freq;
  logic [255:0] ld_dna;
  logic         rd_req;
  logic [2:0]   rd_addr;

  logic         rd_valid, rd_err, core_rst_n, core_run;
  logic [31:0]  rd_data, freq_out;
  logic [7:0]   burn_mask;
  logic [2:0]   seq_state;

  logic         l_rd_valid, l_rd_err, l_core_rst_n, l_core_run;
  logic [31:0]  l_rd_data, l_freq_out;
  logic [7:0]   l_burn_mask;
  logic [2:0]   l_seq_state;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  logic [32:0]  sb [$];
  logic [31:0]  m_word [8];
  logic [7:0]   m_burn;
  logic         m_run;
  logic         m_otp;

  always #5 clk = ~clk;

  genome_core_sequencer #(.ARM_CYCLES(4), .LEASE_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .ld_busy(ld_busy), .ld_enable(ld_enable),
    .ld_otp(ld_otp), .ld_freq(ld_freq), .ld_dna(ld_dna),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .core_rst_n(core_rst_n),
    .core_run(core_run), .freq_out(freq_out), .burn_mask(burn_mask),
    .seq_state(seq_state)
  );

  genome_core_sequencer #(.ARM_CYCLES(4), .LEASE_CYCLES(10)) dut_lease (
    .clk(clk), .rst_n(rst_n), .ld_busy(ld_busy), .ld_enable(ld_enable),
    .ld_otp(ld_otp), .ld_freq(ld_freq), .ld_dna(ld_dna),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(l_rd_valid),
    .rd_data(l_rd_data), .rd_err(l_rd_err), .core_rst_n(l_core_rst_n),
    .core_run(l_core_run), .freq_out(l_freq_out), .burn_mask(l_burn_mask),
    .seq_state(l_seq_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and score any read response.
  task automatic tick();
    logic [32:0] exp;
    @(posedge clk);
    #1;
    if (rd_valid) begin
      exp = (sb.size() != 0) ? sb.pop_front() : 33'h1_DEADBEEF;
      check("rd_rsp", {31'b0, rd_err, rd_data}, {31'b0, exp});
    end
  endtask

  task automatic req(input logic [2:0] a);
    logic ok;
    ok = m_run && !m_burn[a];
    sb.push_back({~ok, ok ? m_word[a] : 32'h0});
    if (ok && m_otp) begin
      m_word[a] = '0;
      m_burn[a] = 1'b1;
      if (&m_burn) m_run = 1'b0;
    end
    rd_req  = 1'b1;
    rd_addr = a;
  endtask

  task automatic do_load(input logic [31:0] f, input logic otp);
    ld_busy   = 1'b1;
    ld_enable = 1'b0;
    m_run     = 1'b0;
    tick();
    check("loading_state", seq_state, 1);
    check("loading_run", core_run, 0);
    check("loading_rst_n", core_rst_n, 0);
    ld_freq = f;
    ld_otp  = otp;
    for (int i = 0; i < 8; i++) ld_dna[32*i +: 32] = 32'h11111111 * 32'(i + 1);
    ld_enable = 1'b1;
    ld_busy   = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("arm_state", seq_state, 2);
      check("arm_rst_n", core_rst_n, 0);
      check("arm_freq", freq_out, 0);
      tick();
    end
    check("prime_state", seq_state, 3);
    check("prime_rst_n", core_rst_n, 1);
    check("prime_run", core_run, 0);
    check("prime_freq", freq_out, f);
    tick();
    check("run_state", seq_state, 4);
    check("run_run", core_run, 1);
    check("run_freq", freq_out, f);
    check("run_burn", burn_mask, 0);
    m_run  = 1'b1;
    m_otp  = otp;
    m_burn = '0;
    for (int i = 0; i < 8; i++) m_word[i] = 32'h11111111 * 32'(i + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rest [7];
    int unsigned run_cycles;
    rst_n = 1'b0; ld_busy = 1'b0; ld_enable = 1'b0; ld_otp = 1'b0;
    ld_freq = '0; ld_dna = '0; rd_req = 1'b0; rd_addr = '0;
    m_run = 1'b0; m_otp = 1'b0; m_burn = '0;
    for (int i = 0; i < 8; i++) m_word[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", seq_state, 0);
    check("rst_rst_n", core_rst_n, 0);
    check("rst_run", core_run, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_freq", freq_out, 0);
    rst_n = 1'b1;
    tick();

    // Plain genome, non-OTP reads including back-to-back.
    do_load(32'h00001000, 1'b0);
    req(3); tick();
    req(0); tick();
    req(7); tick();
    rd_req = 1'b0; tick();
    check("nonotp_burn", burn_mask, 0);

    // OTP genome: burn-on-read until every word is consumed.
    do_load(32'h00001000, 1'b1);
    req(2); tick();
    rd_req = 1'b0; tick();
    check("otp_burn_first", burn_mask, 8'h04);
    req(2); tick();
    rd_req = 1'b0; tick();
    rest = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int i = 0; i < 7; i++) begin
      req(rest[i]);
      tick();
    end
    rd_req = 1'b0;
    check("otp_spent_state", seq_state, 5);
    check("otp_spent_run", core_run, 0);
    check("otp_spent_burn", burn_mask, 8'hFF);
    req(0); tick();
    rd_req = 1'b0; tick();

    // Leased genome on the second instance: exactly ten RUN cycles.
    do_load(32'h00002000, 1'b0);
    run_cycles = 0;
    for (int k = 0; k < 40 && l_core_run; k++) begin
      run_cycles++;
      tick();
    end
    check("lease_run_cycles", run_cycles, 10);
    check("lease_state", l_seq_state, 5);
    req(1); tick();
    rd_req = 1'b0;
    check("lease_rd_valid", l_rd_valid, 1);
    check("lease_rd_err", l_rd_err, 1);
    check("lease_rd_data", l_rd_data, 0);
    tick();

    // Loader abort: busy falls without an enable rise.
    ld_busy = 1'b1; ld_enable = 1'b0; m_run = 1'b0;
    tick();
    check("abort_loading", seq_state, 1);
    check("abort_run_low", core_run, 0);
    ld_busy = 1'b0;
    tick();
    check("abort_state", seq_state, 0);
    check("abort_freq", freq_out, 0);
    tick();
    check("abort_run_stays", core_run, 0);

    // Read collides with a new load starting.
    do_load(32'h00003000, 1'b0);
    m_run = 1'b0;
    ld_busy = 1'b1;
    req(1);
    tick();
    rd_req = 1'b0;
    check("collide_state", seq_state, 1);
    check("collide_run", core_run, 0);
    check("collide_rst_n", core_rst_n, 0);
    ld_busy = 1'b0;
    tick();

    // Asynchronous reset while arming, then a full fresh sequence.
    ld_busy = 1'b1; ld_enable = 1'b0;
    tick();
    ld_freq = 32'h0000ABCD; ld_enable = 1'b1; ld_busy = 1'b0;
    tick();
    check("pre_rst_arming", seq_state, 2);
    rd_req = 1'b1; rd_addr = 3'd0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    check("arm_rd_valid", rd_valid, 1);
    check("arm_rd_err", rd_err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", seq_state, 0);
    check("async_rst_n", core_rst_n, 0);
    check("async_valid", rd_valid, 0);
    check("async_err", rd_err, 0);
    check("async_data", rd_data, 0);
    check("async_freq", freq_out, 0);
    check("async_burn", burn_mask, 0);
    m_run = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_state", seq_state, 0);
    do_load(32'h00004000, 1'b1);
    req(5); tick();
    rd_req = 1'b0; tick();
    check("post_rst_burn", burn_mask, 8'h20);
    tick();

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
